// File: rtl/rv_pkg.sv
// rv_pkg: shared RV32 R-type encoding constants, ALU op codes and encoder FSM state type
package rv_pkg;
    localparam logic [6:0] OPC_RTYPE = 7'b0110011;
    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_OR  = 4'd2;
    localparam logic [3:0] OP_AND = 4'd3;
    localparam logic [3:0] OP_XOR = 4'd4;
    localparam logic [3:0] OP_SLT = 4'd5;
    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_OR      = 3'b110;
    localparam logic [2:0] F3_AND     = 3'b111;
    localparam logic [2:0] F3_XOR     = 3'b100;
    localparam logic [2:0] F3_SLT     = 3'b010;
    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_SUB  = 7'b0100000;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    // Op codes outside ADD..SLT fall through to the ADD encoding.
    function automatic logic [31:0] encode(input logic [3:0] op, input logic [4:0] rd,
                                           input logic [4:0] rs1, input logic [4:0] rs2);
        return {(op == OP_SUB) ? F7_SUB : F7_BASE, rs2, rs1,
                (op == OP_OR)  ? F3_OR  :
                (op == OP_AND) ? F3_AND :
                (op == OP_XOR) ? F3_XOR :
                (op == OP_SLT) ? F3_SLT : F3_ADD_SUB,
                rd, OPC_RTYPE};
    endfunction
endpackage

// File: rtl/rtype_enc_fifo.sv
// rtype_enc_fifo: 2-entry FIFO holding encoded words ahead of the memory write port
// Ports: clk/reset (sync, active high), push_i/data_i write side, pop_i/data_o read side,
// empty_o/full_o status. Callers must not push when full nor pop when empty.
module rtype_enc_fifo #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push_i,
    input  logic [W-1:0] data_i,
    input  logic         pop_i,
    output logic [W-1:0] data_o,
    output logic         empty_o,
    output logic         full_o
);
    logic [W-1:0] mem_q [2];
    logic         rd_q, wr_q;
    logic [1:0]   cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_q  <= 1'b0;
            wr_q  <= 1'b0;
            cnt_q <= 2'd0;
        end else begin
            if (push_i) wr_q <= ~wr_q;
            if (pop_i) rd_q <= ~rd_q;
            cnt_q <= cnt_q + 2'(push_i) - 2'(pop_i);
        end
    end

    always_ff @(posedge clk) begin
        if (push_i) mem_q[wr_q] <= data_i;
    end

    assign data_o  = mem_q[rd_q];
    assign empty_o = cnt_q == 2'd0;
    assign full_o  = cnt_q == 2'd2;
endmodule

// File: rtl/rtype_encoder.sv
// rtype_encoder: turns ALU op requests into R-type instruction words written to instruction memory
// Ports: clk/reset (sync, active high); start/base_addr begin a program; in_* request handshake
// with in_last closing the program; imem_* write port (imem_ready completes a write);
// busy/done status, instr_count words written, err_illegal sticky illegal-op flag.
// Build option RTYPE_ENC_ILLEGAL_CHK_EN: drop op codes 6-15 and flag them instead of encoding as ADD.
module rtype_encoder
    import rv_pkg::*;
#(
    parameter int ADDR_W = 12,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_alu_op,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic              in_last,
    output logic              imem_we,
    input  logic              imem_ready,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  instr_count,
    output logic              err_illegal
);
    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              last_q, last_d, err_q, err_d;
    logic              run, acc, wr, legal, empty, full;
    logic [31:0]       head;

`ifdef RTYPE_ENC_ILLEGAL_CHK_EN
    assign legal = in_alu_op <= OP_SLT;
`else
    assign legal = 1'b1;
`endif

    assign run      = state_q == S_RUN;
    assign in_ready = run && !full && !last_q;
    assign acc      = in_valid && in_ready;
    assign imem_we  = run && !empty;
    assign wr       = imem_we && imem_ready;

    rtype_enc_fifo #(.W(32)) u_fifo (
        .clk    (clk),
        .reset  (reset),
        .push_i (acc && legal),
        .data_i (encode(in_alu_op, in_rd, in_rs1, in_rs2)),
        .pop_i  (wr),
        .data_o (head),
        .empty_o(empty),
        .full_o (full)
    );

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: if (start) begin
                state_d = S_RUN;
                addr_d  = base_addr;
                cnt_d   = '0;
                last_d  = 1'b0;
                err_d   = 1'b0;
            end
            S_RUN: begin
                if (wr) begin
                    addr_d = addr_q + ADDR_W'(4);
                    cnt_d  = &cnt_q ? cnt_q : cnt_q + CNT_W'(1);
                end
                if (acc && in_last) last_d = 1'b1;
                if (acc && !legal) err_d = 1'b1;
                if (last_q && empty) state_d = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            cnt_q   <= '0;
            last_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            err_q   <= err_d;
        end
    end

    // Gating keeps the data bus at zero whenever no write is being offered.
    assign imem_wdata  = imem_we ? head : 32'd0;
    assign imem_addr   = addr_q;
    assign busy        = run;
    assign done        = state_q == S_DONE;
    assign instr_count = cnt_q;
    assign err_illegal = err_q;
endmodule

// File: tb/tb_rtype_encoder.sv
// tb_rtype_encoder: queue-based reference model plus directed literal checks for rtype_encoder
module tb_rtype_encoder;
    localparam int ADDR_W = 12;
    localparam int CNT_W  = 16;

    logic              clk = 0, reset = 1, start = 0, in_valid = 0, in_last = 0, imem_ready = 0;
    logic [ADDR_W-1:0] base_addr = '0;
    logic [3:0]        in_alu_op = '0;
    logic [4:0]        in_rd = '0, in_rs1 = '0, in_rs2 = '0;
    logic              in_ready, imem_we, busy, done, err_illegal;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic [CNT_W-1:0]  instr_count;

    rtype_encoder #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
        .in_valid(in_valid), .in_ready(in_ready), .in_alu_op(in_alu_op),
        .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_last(in_last),
        .imem_we(imem_we), .imem_ready(imem_ready), .imem_addr(imem_addr),
        .imem_wdata(imem_wdata), .busy(busy), .done(done),
        .instr_count(instr_count), .err_illegal(err_illegal)
    );

    always #5 clk = ~clk;

    int compared = 0, mismatched = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Instruction word built from field values with plain arithmetic.
    function automatic logic [31:0] enc(input int op, input int rd, input int rs1, input int rs2);
        int f3, f7;
        case (op)
            2: f3 = 6;
            3: f3 = 7;
            4: f3 = 4;
            5: f3 = 2;
            default: f3 = 0;
        endcase
        f7 = (op == 1) ? 32 : 0;
        return 32'(f7 * (1 << 25) + rs2 * (1 << 20) + rs1 * (1 << 15) + f3 * (1 << 12) + rd * (1 << 7) + 51);
    endfunction

    // Reference model: phase 0 idle, 1 running, 2 done; mq holds words awaiting write.
    int          mphase = 0, maddr = 0, mcnt = 0;
    bit          mlast = 0, merr = 0, armed = 0;
    logic [31:0] mq[$];
    logic [31:0] log_d[$];
    int          log_a[$];
    int          hold_low = 0;

    always @(negedge clk) if (armed) begin
        bit          e_we, e_rdy, acc, wr, legal, fin;
        logic [31:0] e_wd;
        int          op;
        e_we  = mphase == 1 && mq.size() > 0;
        e_rdy = mphase == 1 && mq.size() < 2 && !mlast;
        e_wd  = e_we ? mq[0] : 32'd0;
        chk("imem_we", imem_we, e_we);
        chk("in_ready", in_ready, e_rdy);
        chk("imem_wdata", imem_wdata, e_wd);
        chk("imem_addr", imem_addr, maddr);
        chk("busy", busy, mphase == 1);
        chk("done", done, mphase == 2);
        chk("instr_count", instr_count, mcnt);
        chk("err_illegal", err_illegal, merr);
        if (imem_we && imem_ready) begin
            log_d.push_back(imem_wdata);
            log_a.push_back(int'(imem_addr));
        end
        if (reset) begin
            mphase = 0; mq.delete(); maddr = 0; mcnt = 0; mlast = 0; merr = 0;
        end else if (mphase == 0) begin
            if (start) begin
                mphase = 1; maddr = int'(base_addr); mcnt = 0; mlast = 0; merr = 0;
            end
        end else if (mphase == 1) begin
            fin = mlast && mq.size() == 0;
            acc = e_rdy && in_valid;
            wr  = e_we && imem_ready;
            if (wr) begin
                void'(mq.pop_front());
                maddr = (maddr + 4) % (1 << ADDR_W);
                if (mcnt < (1 << CNT_W) - 1) mcnt++;
            end
            if (acc) begin
                op = int'(in_alu_op);
`ifdef RTYPE_ENC_ILLEGAL_CHK_EN
                legal = op < 6;
`else
                legal = 1;
`endif
                if (legal) mq.push_back(enc(op, in_rd, in_rs1, in_rs2));
                else merr = 1;
                if (in_last) mlast = 1;
            end
            if (fin) mphase = 2;
        end else begin
            mphase = 0;
        end
    end

    always @(posedge clk) begin
        #2;
        if (hold_low > 0) begin
            imem_ready = 0;
            hold_low--;
        end else imem_ready = ($urandom_range(0, 3) != 0);
    end

    task automatic do_start(input int base);
        base_addr = ADDR_W'(base);
        start = 1;
        @(posedge clk); #1;
        start = 0;
    endtask

    task automatic send(input int op, input int rd, input int rs1, input int rs2, input bit last);
        in_valid = 1; in_alu_op = 4'(op); in_rd = 5'(rd); in_rs1 = 5'(rs1); in_rs2 = 5'(rs2); in_last = last;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (in_ready) begin
                @(posedge clk); #1;
                in_valid = 0; in_last = 0;
                return;
            end
        end
        compared++; mismatched++;
        $display("FAIL send_timeout: in_ready stayed 0, want 1");
        in_valid = 0; in_last = 0;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (done) begin
                @(posedge clk); #1;
                return;
            end
        end
        compared++; mismatched++;
        $display("FAIL done_timeout: done stayed 0, want 1");
    endtask

    function automatic logic [31:0] ld(input int i);
        return log_d.size() > i ? log_d[i] : 32'hDEAD_BEEF;
    endfunction

    function automatic logic [31:0] la(input int i);
        return log_a.size() > i ? 32'(log_a[i]) : 32'hDEAD_BEEF;
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1;
        @(posedge clk); #1;
        armed = 1;
        @(posedge clk); #1;
        chk("rst_we", imem_we, 0);
        chk("rst_addr", imem_addr, 0);
        chk("rst_wdata", imem_wdata, 0);
        chk("rst_busy", busy, 0);
        chk("rst_count", instr_count, 0);
        reset = 0;
        @(posedge clk); #1;

        log_d.delete(); log_a.delete();
        do_start('h100);
        send(0, 1, 2, 3, 1);
        wait_done();
        chk("add_nwrites", log_d.size(), 1);
        chk("add_word", ld(0), 32'h003100B3);
        chk("add_addr", la(0), 32'h100);
        chk("add_count", instr_count, 1);

        log_d.delete(); log_a.delete();
        do_start('h200);
        send(1, 5, 6, 7, 1);
        wait_done();
        chk("sub_word", ld(0), 32'h407302B3);

        log_d.delete(); log_a.delete();
        do_start('h100);
        hold_low = 4;
        send(0, 1, 2, 3, 0);
        send(1, 5, 6, 7, 0);
        chk("full_in_ready", in_ready, 0);
        chk("stall_wdata", imem_wdata, 32'h003100B3);
        send(2, 8, 9, 10, 0);
        send(3, 11, 12, 13, 1);
        wait_done();
        chk("burst_nwrites", log_d.size(), 4);
        chk("burst_a0", la(0), 32'h100);
        chk("burst_a1", la(1), 32'h104);
        chk("burst_a2", la(2), 32'h108);
        chk("burst_a3", la(3), 32'h10C);
        chk("burst_d1", ld(1), 32'h407302B3);
        chk("burst_count", instr_count, 4);

        log_d.delete(); log_a.delete();
        do_start('hFFC);
        send(2, 1, 1, 1, 0);
        send(3, 2, 2, 2, 1);
        wait_done();
        chk("wrap_a0", la(0), 32'hFFC);
        chk("wrap_a1", la(1), 32'h000);

        log_d.delete(); log_a.delete();
        do_start('h300);
        send(9, 1, 2, 3, 1);
        wait_done();
`ifdef RTYPE_ENC_ILLEGAL_CHK_EN
        chk("illegal_nwrites", log_d.size(), 0);
        chk("illegal_err", err_illegal, 1);
`else
        chk("illegal_as_add", ld(0), 32'h003100B3);
        chk("illegal_err", err_illegal, 0);
`endif

        log_d.delete(); log_a.delete();
        do_start('h100);
        hold_low = 10;
        send(0, 1, 2, 3, 0);
        send(1, 5, 6, 7, 0);
        reset = 1;
        @(posedge clk); #1;
        reset = 0;
        chk("midrst_we", imem_we, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_count", instr_count, 0);
        repeat (12) @(posedge clk);
        #1;
        chk("midrst_nwrites", log_d.size(), 0);

        for (int p = 0; p < 25; p++) begin
            int len;
            do_start(int'($urandom_range(0, (1 << ADDR_W) - 1)) & ~3);
            len = int'($urandom_range(1, 8));
            for (int b = 0; b < len; b++) begin
                int op;
                op = ($urandom_range(0, 4) == 0) ? int'($urandom_range(6, 15)) : int'($urandom_range(0, 5));
                if ($urandom_range(0, 2) == 0) repeat ($urandom_range(1, 3)) begin @(posedge clk); #1; end
                start = ($urandom_range(0, 3) == 0);
                send(op, int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
                     int'($urandom_range(0, 31)), b == len - 1);
                start = 0;
            end
            wait_done();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
